// File: rtl/regfile_multiport.sv
// regfile_multiport: parametrised multi-read, single-write register file with
// optional hardwired-zero entry 0, a sequenced bulk-clear engine and a sticky
// dropped-write flag. All state changes on the falling edge of CLK.
//
// Optional feature macro: REGFILE_BYPASS_EN
//   defined   -> a write accepted this cycle is forwarded combinationally to
//                any read port addressing the same entry
//   undefined -> read data reflects the array contents only
//
// state | meaning
// ------+-------------------------------------------------------------
// IDLE  | normal operation, writes accepted, waiting for ClrReq
// CLEAR | sweeping entries FIRST..DEPTH-1 to zero, one per cycle; Busy=1

module regfile_multiport #(
    parameter int DATA_W   = 32,
    parameter int ADDR_W   = 5,
    parameter int DEPTH    = 32,
    parameter int NUM_RD   = 2,
    parameter int ZERO_REG = 1
) (
    input  logic                     CLK,
    input  logic                     RST,
    input  logic                     RegWre,
    input  logic [ADDR_W-1:0]        WriteReg,
    input  logic [DATA_W-1:0]        WriteData,
    input  logic [NUM_RD*ADDR_W-1:0] ReadRegs,
    output logic [NUM_RD*DATA_W-1:0] ReadDatas,
    input  logic                     ClrReq,
    output logic                     Busy,
    output logic                     WrDrop
);

    localparam int                FIRST   = (ZERO_REG != 0) ? 1 : 0;
    localparam logic [ADDR_W:0]   DEPTH_W = DEPTH[ADDR_W:0];
    localparam logic [ADDR_W-1:0] PTR_LO  = ADDR_W'(FIRST);
    localparam logic [ADDR_W-1:0] PTR_HI  = ADDR_W'(DEPTH - 1);

    typedef enum logic {
        IDLE  = 1'b0,
        CLEAR = 1'b1
    } state_t;

    state_t              state, state_nxt;
    logic [ADDR_W-1:0]   ptr, ptr_nxt;
    logic [DATA_W-1:0]   mem [DEPTH];
    logic                wr_ok;

    // Entry 0 is unwritable when hardwired; out-of-range writes vanish quietly.
    assign Busy  = (state == CLEAR);
    assign wr_ok = RegWre && !Busy
                   && ({1'b0, WriteReg} < DEPTH_W)
                   && !((ZERO_REG != 0) && (WriteReg == '0));

    // Clear-engine state and sweep pointer.
    always_ff @(negedge CLK or negedge RST) begin
        if (!RST) begin
            state <= IDLE;
            ptr   <= '0;
        end else begin
            state <= state_nxt;
            ptr   <= ptr_nxt;
        end
    end

    // Next state: ClrReq only matters in IDLE, so no restart while sweeping.
    always_comb begin
        state_nxt = state;
        ptr_nxt   = ptr;
        case (state)
            IDLE: begin
                if (ClrReq) begin
                    state_nxt = CLEAR;
                    ptr_nxt   = PTR_LO;
                end
            end
            CLEAR: begin
                if (ptr == PTR_HI) begin
                    state_nxt = IDLE;
                    ptr_nxt   = '0;
                end else begin
                    ptr_nxt = ptr + ADDR_W'(1);
                end
            end
            default: begin
                state_nxt = IDLE;
                ptr_nxt   = '0;
            end
        endcase
    end

    // Storage: the sweep and normal writes are mutually exclusive via Busy.
    always_ff @(negedge CLK or negedge RST) begin
        if (!RST) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else if (Busy) begin
            mem[ptr] <= '0;
        end else if (wr_ok) begin
            mem[WriteReg] <= WriteData;
        end
    end

    // Sticky record of any write attempted during a sweep.
    always_ff @(negedge CLK or negedge RST) begin
        if (!RST) begin
            WrDrop <= 1'b0;
        end else if (RegWre && Busy) begin
            WrDrop <= 1'b1;
        end
    end

    for (genvar k = 0; k < NUM_RD; k++) begin : g_rd
        logic [ADDR_W-1:0] rd_addr;
        logic              rd_valid;
        logic              fwd;

        assign rd_addr  = ReadRegs[k*ADDR_W +: ADDR_W];
        assign rd_valid = ({1'b0, rd_addr} < DEPTH_W)
                          && !((ZERO_REG != 0) && (rd_addr == '0));
`ifdef REGFILE_BYPASS_EN
        assign fwd      = wr_ok && (WriteReg == rd_addr);
`else
        assign fwd      = 1'b0;
`endif
        assign ReadDatas[k*DATA_W +: DATA_W] = fwd      ? WriteData :
                                               rd_valid ? mem[rd_addr] : '0;
    end

endmodule

// File: tb/tb_regfile_multiport.sv
// Directed bench for regfile_multiport: default instance plus a small
// DEPTH=20 / ZERO_REG=0 instance for range and entry-0 behaviour.

module tb_regfile_multiport;

    logic        CLK = 1'b1;
    logic        RST = 1'b0;
    logic        RegWre = 1'b0;
    logic [4:0]  WriteReg = '0;
    logic [31:0] WriteData = '0;
    logic [9:0]  ReadRegs = '0;
    logic [63:0] ReadDatas;
    logic        ClrReq = 1'b0;
    logic        Busy;
    logic        WrDrop;

    logic        s_we = 1'b0;
    logic [4:0]  s_wa = '0;
    logic [31:0] s_wd = '0;
    logic [4:0]  s_ra = '0;
    logic [31:0] s_rd;
    logic        s_clr = 1'b0;
    logic        s_busy;
    logic        s_drop;

    int n_cmp = 0;
    int n_bad = 0;
    logic [31:0] exp_q [$];

    regfile_multiport u_dut (
        .CLK(CLK), .RST(RST), .RegWre(RegWre), .WriteReg(WriteReg),
        .WriteData(WriteData), .ReadRegs(ReadRegs), .ReadDatas(ReadDatas),
        .ClrReq(ClrReq), .Busy(Busy), .WrDrop(WrDrop)
    );

    regfile_multiport #(.DATA_W(32), .ADDR_W(5), .DEPTH(20), .NUM_RD(1), .ZERO_REG(0)) u_small (
        .CLK(CLK), .RST(RST), .RegWre(s_we), .WriteReg(s_wa),
        .WriteData(s_wd), .ReadRegs(s_ra), .ReadDatas(s_rd),
        .ClrReq(s_clr), .Busy(s_busy), .WrDrop(s_drop)
    );

    initial forever #5 CLK = ~CLK;

    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    task automatic sb_push(input logic [31:0] e);
        exp_q.push_back(e);
    endtask

    task automatic sb_check(input string tag, input logic [31:0] obs);
        logic [31:0] e;
        e = (exp_q.size() != 0) ? exp_q.pop_front() : 32'hxxxx_xxxx;
        n_cmp++;
        assert (obs === e) else begin
            n_bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, e);
        end
    endtask

    task automatic tick();
        @(negedge CLK);
        #1;
    endtask

    task automatic wr(input int a, input logic [31:0] d);
        RegWre    = 1'b1;
        WriteReg  = a[4:0];
        WriteData = d;
        tick();
        RegWre    = 1'b0;
    endtask

    task automatic rd_main(input int port, input int a, input logic [31:0] e, input string tag);
        ReadRegs[port*5 +: 5] = a[4:0];
        sb_push(e);
        #1;
        sb_check(tag, ReadDatas[port*32 +: 32]);
    endtask

    task automatic flags(input logic eb, input logic ed, input string tag);
        sb_push({31'b0, eb});
        sb_check({tag, "_busy"}, {31'b0, Busy});
        sb_push({31'b0, ed});
        sb_check({tag, "_wrdrop"}, {31'b0, WrDrop});
    endtask

    task automatic sweep_len(input int already, input string tag);
        int cyc;
        cyc = already;
        while (Busy && cyc < 100) begin
            tick();
            cyc++;
        end
        sb_push(32'd31);
        sb_check(tag, cyc);
    endtask

    initial begin
        // reset then read
        #12;
        RST = 1'b1;
        tick();
        for (int i = 0; i < 32; i++) begin
            rd_main(0, i, 32'h0, "reset_rd_p0");
            rd_main(1, i, 32'h0, "reset_rd_p1");
        end
        flags(1'b0, 1'b0, "reset");

        // write then read, hardwired zero
        wr(5, 32'hDEAD_BEEF);
        wr(31, 32'h1234_5678);
        rd_main(0, 5, 32'hDEAD_BEEF, "wr_rd_5");
        rd_main(1, 31, 32'h1234_5678, "wr_rd_31");
        rd_main(1, 5, 32'hDEAD_BEEF, "same_addr_p1");
        wr(0, 32'hFFFF_FFFF);
        rd_main(0, 0, 32'h0, "zero_reg_p0");
        rd_main(1, 0, 32'h0, "zero_reg_p1");
        flags(1'b0, 1'b0, "after_writes");

        // forwarding (or not) before the edge, array value after
        wr(9, 32'h1);
        RegWre = 1'b1; WriteReg = 5'd9; WriteData = 32'h55;
`ifdef REGFILE_BYPASS_EN
        rd_main(0, 9, 32'h55, "bypass_pre_edge");
`else
        rd_main(0, 9, 32'h1, "nobypass_pre_edge");
`endif
        tick();
        RegWre = 1'b0;
        rd_main(0, 9, 32'h55, "post_edge_9");

        // small instance: DEPTH=20, entry 0 is ordinary
        s_we = 1'b1; s_wa = 5'd25; s_wd = 32'h77; tick();
        s_wa = 5'd0;  s_wd = 32'h11; tick();
        s_wa = 5'd19; s_wd = 32'h22; tick();
        s_we = 1'b0;
        s_ra = 5'd25; sb_push(32'h0);  #1; sb_check("small_oor_25", s_rd);
        s_ra = 5'd0;  sb_push(32'h11); #1; sb_check("small_reg0", s_rd);
        s_ra = 5'd19; sb_push(32'h22); #1; sb_check("small_reg19", s_rd);
        s_ra = 5'd6;  sb_push(32'h0);  #1; sb_check("small_alias_6", s_rd);
        sb_push(32'h0); sb_check("small_wrdrop", {31'b0, s_drop});

        // bulk clear with a dropped write
        for (int i = 1; i < 32; i++) wr(i, i);
        ClrReq = 1'b1; tick(); ClrReq = 1'b0;
        flags(1'b1, 1'b0, "sweep_start");
        repeat (10) tick();
        rd_main(0, 1, 32'h0, "mid_sweep_1");
        rd_main(1, 10, 32'h0, "mid_sweep_10");
        rd_main(0, 11, 32'd11, "mid_sweep_11");
        rd_main(1, 31, 32'd31, "mid_sweep_31");
        RegWre = 1'b1; WriteReg = 5'd3; WriteData = 32'hAAAA;
        tick();
        RegWre = 1'b0;
        flags(1'b1, 1'b1, "drop_in_sweep");
        sweep_len(11, "sweep_cycles");
        for (int i = 0; i < 32; i++) rd_main(1, i, 32'h0, "post_sweep_zero");
        flags(1'b0, 1'b1, "post_sweep");

        // reset mid-sweep, then a fresh full sweep
        wr(20, 32'h20);
        wr(31, 32'h31);
        rd_main(0, 20, 32'h20, "pre_abort_20");
        ClrReq = 1'b1; tick(); ClrReq = 1'b0;
        repeat (6) tick();
        RST = 1'b0;
        #1;
        flags(1'b0, 1'b0, "abort");
        rd_main(0, 20, 32'h0, "abort_rd_20");
        rd_main(1, 31, 32'h0, "abort_rd_31");
        RST = 1'b1;
        tick();
        ClrReq = 1'b1; tick(); ClrReq = 1'b0;
        flags(1'b1, 1'b0, "resweep_start");
        sweep_len(0, "resweep_cycles");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/regfile_multiport.md
Name: regfile_multiport

Overview:
- Parametrised successor to the CPU's single-write, dual-read register file.
- Configurable data width, depth and read-port count; optional hardwired-zero entry 0.
- Adds a sequenced bulk-clear engine with a Busy flag, plus a sticky dropped-write indicator.
- Sits in the datapath between decode (read addresses) and write-back (write port).

Parameters:
DATA_W, 32, width of each register in bits
ADDR_W, 5, register address width in bits
DEPTH, 32, number of implemented registers; must satisfy 2 <= DEPTH <= 2**ADDR_W
NUM_RD, 2, number of independent read ports; must be >= 1
ZERO_REG, 1, 1 = entry 0 is hardwired to zero and never written; 0 = entry 0 is an ordinary register

Ports:
CLK  input  1  clock; all state updates occur on the falling edge
RST  input  1  asynchronous, active-low reset
RegWre  input  1  write enable
WriteReg  input  ADDR_W  write address
WriteData  input  DATA_W  write data
ReadRegs  input  NUM_RD*ADDR_W  packed read addresses; port k uses bits [k*ADDR_W +: ADDR_W]
ReadDatas  output  NUM_RD*DATA_W  packed read data; port k uses bits [k*DATA_W +: DATA_W]
ClrReq  input  1  start a bulk clear; one-cycle pulse or level
Busy  output  1  bulk clear in progress
WrDrop  output  1  sticky flag: at least one write was discarded because Busy was high

Behaviour:
- Reset (RST=0, asynchronous):
  - all entries cleared to 0
  - FSM goes to IDLE, Busy=0, WrDrop=0, clear pointer=0
- Reads are combinational. For each port k:
  - ReadDatas[k] = 0 if ZERO_REG=1 and the address is 0
  - ReadDatas[k] = 0 if the address is >= DEPTH
  - otherwise ReadDatas[k] = the array entry
  - Ports are independent; several ports may read the same address.
- Write, on the falling edge of CLK:
  - Accepted only when RegWre=1, Busy=0, WriteReg < DEPTH, and not (ZERO_REG=1 and WriteReg=0).
  - A write to an out-of-range address or to hardwired entry 0 is silently ignored; WrDrop is not set.
  - If RegWre=1 while Busy=1, the write is discarded and WrDrop is set to 1.
  - WrDrop is cleared only by reset.
- Clear FSM, states IDLE and CLEAR. Let FIRST = ZERO_REG ? 1 : 0.
  - IDLE: on a falling edge with ClrReq=1, go to CLEAR with ptr=FIRST.
  - CLEAR: each falling edge writes 0 to entry ptr.
    - If ptr == DEPTH-1, return to IDLE.
    - Otherwise increment ptr.
  - Busy is 1 exactly while the FSM is in CLEAR (registered, changes only on falling edges).
  - Busy stays high for DEPTH-FIRST cycles; 31 cycles with the default parameters.
  - ClrReq while Busy=1 is ignored; there is no restart and no queuing.
  - If ClrReq is held high, a new sweep starts on the falling edge after Busy drops.
  - Reads during CLEAR return the current, partially cleared contents.
- Reset mid-sweep: the sweep aborts immediately, all entries read 0, and the FSM is in IDLE.
- A write accepted on falling edge n is visible on the read ports after that edge, with no extra latency.
- The pointer is ADDR_W bits wide and never exceeds DEPTH-1.

Optional Feature:
REGFILE_BYPASS_EN
- Defined: write-to-read forwarding. If a write would be accepted this cycle and WriteReg equals read address k, ReadDatas[k] = WriteData combinationally, before the falling edge.
  - Forwarding never applies when Busy=1, for out-of-range addresses, or for hardwired entry 0.
- Undefined: no forwarding; read data reflects the array contents only.

Test Plan:
1. Reset then read: RST pulse low, read addresses 0..31 on both ports -> every read returns 0; Busy=0, WrDrop=0.
2. Write then read: write 0xDEADBEEF to register 5 and 0x12345678 to register 31; after the falling edge read 5 on port 0 and 31 on port 1 -> 0xDEADBEEF and 0x12345678. Write 0xFFFFFFFF to register 0 -> a read of 0 returns 0.
3. Bulk clear: fill registers 1..31 with value = index, pulse ClrReq -> Busy high for exactly 31 cycles.
   - Mid-sweep, after 10 cycles, registers 1..10 read 0 and register 11 reads 11.
   - After Busy falls, all registers read 0.
4. Write during Busy: during the sweep, write 0xAAAA to register 3 -> the write is discarded, WrDrop becomes 1 and stays 1 after the sweep; only RST clears it.
5. Reset mid-sweep: assert RST low on cycle 7 of the sweep -> Busy drops asynchronously and all registers read 0. The next ClrReq starts a fresh 31-cycle sweep.
6. Bypass (REGFILE_BYPASS_EN defined): register 9 holds 0x1, present a write of 0x55 to register 9 while reading it -> reads 0x55 before the edge. With the macro undefined, it reads 0x1 before the edge and 0x55 after.
   - Also with DEPTH=20, ZERO_REG=0: a write to 25 is ignored and a read of 25 returns 0.
